// File: rtl/exe_muldiv_unit_if.sv
// Request/result bundle between the EXE stage (master) and the mul/div unit (slave).
interface exe_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op_code;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, op_code, src1, src2, flush,
        input  op_ready, busy, done, hi, lo
    );
    modport slave (
        input  op_valid, op_code, src1, src2, flush,
        output op_ready, busy, done, hi, lo
    );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Iterative HI/LO mul/div unit for EXE; define MULDIV_ACC_EN for true MADD/MSUB accumulate.
// Latency to done: mul-class WIDTH/MUL_BITS+2, div-class WIDTH+2, MTHI/MTLO/illegal 1.
// Backpressure: op_ready only in IDLE without flush; flush or reset drops the in-flight op silently.
module exe_muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    exe_muldiv_unit_if.slave io
);
    localparam int W2        = 2 * WIDTH;
    localparam int MUL_STEPS = WIDTH / MUL_BITS;
    localparam int CW        = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             neg_main, neg_rem, div_op, div_zero, wr_hi, wr_lo;
    logic [WIDTH-1:0] src1_q, divisor, rem, shreg;
    logic [WIDTH-1:0] res_hi, res_lo, hi_r, lo_r;
    logic [W2-1:0]    acc, mcand;
`ifdef MULDIV_ACC_EN
    logic             acc_add, acc_sub;
    logic [W2-1:0]    snap;
`endif

    logic             is_mul, is_div, s1_neg, s2_neg, div_ge;
    logic [WIDTH-1:0] mag1, mag2, quo, remv;
    logic [W2-1:0]    partial, prod, fixed;
    logic [WIDTH:0]   div_shift;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        case (io.op_code)
            4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: is_mul = 1'b1;
            4'd2, 4'd3:                         is_div = 1'b1;
            default: ;
        endcase
    end

    // Even op codes are the signed variants; iterate on magnitudes and fix signs at the end
    assign s1_neg = ~io.op_code[0] & io.src1[WIDTH-1];
    assign s2_neg = ~io.op_code[0] & io.src2[WIDTH-1];
    assign mag1   = s1_neg ? -io.src1 : io.src1;
    assign mag2   = s2_neg ? -io.src2 : io.src2;

    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BITS; i++)
            if (shreg[i]) partial = partial + (mcand << i);
    end

    // Restoring step: shreg doubles as dividend source and quotient sink
    assign div_shift = {rem, shreg[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, divisor};

    assign prod = neg_main ? -acc : acc;
    assign quo  = neg_main ? -shreg : shreg;
    assign remv = neg_rem ? -rem : rem;
`ifdef MULDIV_ACC_EN
    always_comb begin
        fixed = prod;
        if (acc_add)      fixed = snap + prod;
        else if (acc_sub) fixed = snap - prod;
    end
`else
    assign fixed = prod;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_op   <= 1'b0;
            div_zero <= 1'b0;
            wr_hi    <= 1'b0;
            wr_lo    <= 1'b0;
            src1_q   <= '0;
            divisor  <= '0;
            rem      <= '0;
            shreg    <= '0;
            res_hi   <= '0;
            res_lo   <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            acc      <= '0;
            mcand    <= '0;
`ifdef MULDIV_ACC_EN
            acc_add  <= 1'b0;
            acc_sub  <= 1'b0;
            snap     <= '0;
`endif
        end else if (state != S_IDLE && io.flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (io.op_valid && !io.flush) begin
                    cnt      <= '0;
                    src1_q   <= io.src1;
                    neg_main <= s1_neg ^ s2_neg;
                    neg_rem  <= s1_neg;
                    div_op   <= is_div;
                    div_zero <= (io.src2 == '0);
                    wr_hi    <= (io.op_code == 4'd8);
                    wr_lo    <= (io.op_code == 4'd9);
                    res_hi   <= io.src1;
                    res_lo   <= io.src1;
                    acc      <= '0;
                    mcand    <= {{WIDTH{1'b0}}, mag1};
`ifdef MULDIV_ACC_EN
                    acc_add  <= (io.op_code == 4'd4) || (io.op_code == 4'd5);
                    acc_sub  <= (io.op_code == 4'd6) || (io.op_code == 4'd7);
                    snap     <= {hi_r, lo_r};
`endif
                    if (is_mul) begin
                        shreg <= mag2;
                        state <= S_MUL;
                    end else if (is_div) begin
                        rem     <= '0;
                        shreg   <= mag1;
                        divisor <= mag2;
                        state   <= S_DIV;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_MUL: begin
                    acc   <= acc + partial;
                    mcand <= mcand << MUL_BITS;
                    shreg <= shreg >> MUL_BITS;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(MUL_STEPS - 1)) state <= S_FIX;
                end
                S_DIV: begin
                    rem   <= div_ge ? (div_shift[WIDTH-1:0] - divisor) : div_shift[WIDTH-1:0];
                    shreg <= {shreg[WIDTH-2:0], div_ge};
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    wr_hi <= 1'b1;
                    wr_lo <= 1'b1;
                    if (div_op) begin
                        res_lo <= div_zero ? '1 : quo;
                        res_hi <= div_zero ? src1_q : remv;
                    end else begin
                        {res_hi, res_lo} <= fixed;
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (wr_hi) hi_r <= res_hi;
                    if (wr_lo) lo_r <= res_lo;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign io.op_ready = (state == S_IDLE) & ~io.flush;
    assign io.busy     = (state != S_IDLE);
    assign io.done     = (state == S_DONE) & ~io.flush;
    assign io.hi       = hi_r;
    assign io.lo       = lo_r;
endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed bench: arithmetic reference model + cycle-level scoreboard for the 32-bit unit,
// literal checks from worked examples, and a 16-bit/radix-16 instance.
module tb_exe_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_muldiv_unit_if #(.WIDTH(32)) ifa ();
    exe_muldiv_unit_if #(.WIDTH(16)) ifb ();

    exe_muldiv_unit #(.WIDTH(32), .MUL_BITS(2)) dut_a (.clk(clk), .reset(rst), .io(ifa));
    exe_muldiv_unit #(.WIDTH(16), .MUL_BITS(4)) dut_b (.clk(clk), .reset(rst), .io(ifb));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result as {hi, lo}, from plain integer arithmetic on the architectural values
    function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [63:0] hl);
        longint      va, vb, q, r;
        logic [63:0] p;
        bit          sgn;
        sgn = !op[0];
        va  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        vb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        case (op)
            4'd2, 4'd3: begin
                if (vb == 0) return {a, 32'hFFFF_FFFF};
                q = va / vb;
                r = va % vb;
                return {r[31:0], q[31:0]};
            end
            4'd8: return {a, hl[31:0]};
            4'd9: return {hl[63:32], a};
            4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: begin
                p = va * vb;
`ifdef MULDIV_ACC_EN
                if (op == 4'd4 || op == 4'd5)      p = hl + p;
                else if (op == 4'd6 || op == 4'd7) p = hl - p;
`endif
                return p;
            end
            default: return hl;
        endcase
    endfunction

    function automatic int latency_of(input logic [3:0] op);
        if (op == 4'd2 || op == 4'd3) return 32 + 2;
        if (op <= 4'd7) return 32 / 2 + 2;
        return 1;
    endfunction

    // Scoreboard for dut_a: one pending op with its accept cycle and known latency
    int          cyc = 0;
    int          t_acc = 0;
    int          lat = 0;
    bit          pend = 0;
    bit          chk_en = 0;
    logic [31:0] mh = '0;
    logic [31:0] ml = '0;
    logic [63:0] m_res = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mh = '0;
            ml = '0;
            pend = 0;
        end else if (pend) begin
            if (ifa.flush) pend = 0;
            else if (cyc == t_acc + lat) begin
                {mh, ml} = m_res;
                pend = 0;
            end
        end else if (ifa.op_valid && !ifa.flush) begin
            m_res = model_result(ifa.op_code, ifa.src1, ifa.src2, {mh, ml});
            t_acc = cyc;
            lat   = latency_of(ifa.op_code);
            pend  = 1;
        end
    end

    always begin
        @(negedge clk);
        #1;
        if (chk_en) begin
            chk("sb_busy", 64'(ifa.busy), 64'(pend));
            chk("sb_done", 64'(ifa.done), 64'(pend && (cyc == t_acc + lat - 1) && !ifa.flush));
            chk("sb_ready", 64'(ifa.op_ready), 64'(!pend && !ifa.flush));
            chk("sb_hi", 64'(ifa.hi), 64'(mh));
            chk("sb_lo", 64'(ifa.lo), 64'(ml));
        end
    end

    // Called at negedge+1 of the first cycle after accept; returns at the negedge after the write
    task automatic wait_done(output int l);
        l = -1;
        for (int j = 0; j < 200; j++) begin
            if (ifa.done) begin
                l = j + 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int l);
        int k;
        ifa.op_code  = op;
        ifa.src1     = a;
        ifa.src2     = b;
        ifa.op_valid = 1'b1;
        k = 0;
        #1;
        while (!ifa.op_ready && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        @(negedge clk);
        ifa.op_valid = 1'b0;
        ifa.src1     = ~a;
        ifa.src2     = ~b;
        #1;
        wait_done(l);
    endtask

    int          l, k;
    logic [31:0] ph, pl;

    initial begin
        ifa.op_valid = 1'b0; ifa.op_code = '0; ifa.src1 = '0; ifa.src2 = '0; ifa.flush = 1'b0;
        ifb.op_valid = 1'b0; ifb.op_code = '0; ifb.src1 = '0; ifb.src2 = '0; ifb.flush = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1;
        #1;
        chk("reset_hi", 64'(ifa.hi), 64'd0);
        chk("reset_lo", 64'(ifa.lo), 64'd0);
        chk("reset_busy", 64'(ifa.busy), 64'd0);
        chk("reset_done", 64'(ifa.done), 64'd0);
        chk("reset_ready", 64'(ifa.op_ready), 64'd1);
        @(negedge clk);

        issue(4'd0, 32'hFFFF_FFFF, 32'h2, l);
        chk("mult_lat", 64'(l), 64'd18);
        chk("mult_hi", 64'(ifa.hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(ifa.lo), 64'hFFFF_FFFE);
        issue(4'd1, 32'hFFFF_FFFF, 32'h2, l);
        chk("multu_hi", 64'(ifa.hi), 64'h1);
        chk("multu_lo", 64'(ifa.lo), 64'hFFFF_FFFE);

        issue(4'd2, 32'hFFFF_FFF9, 32'h2, l);
        chk("div_lat", 64'(l), 64'd34);
        chk("div_lo", 64'(ifa.lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(ifa.hi), 64'hFFFF_FFFF);
        issue(4'd3, 32'h7, 32'h0, l);
        chk("divu0_lo", 64'(ifa.lo), 64'hFFFF_FFFF);
        chk("divu0_hi", 64'(ifa.hi), 64'h7);
        issue(4'd2, 32'hFFFF_FFF9, 32'h0, l);
        chk("div0_lo", 64'(ifa.lo), 64'hFFFF_FFFF);
        chk("div0_hi", 64'(ifa.hi), 64'hFFFF_FFF9);
        issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, l);
        chk("divovf_lo", 64'(ifa.lo), 64'h8000_0000);
        chk("divovf_hi", 64'(ifa.hi), 64'h0);

        issue(4'd9, 32'h5, 32'h0, l);
        chk("mtlo_lat", 64'(l), 64'd1);
        issue(4'd8, 32'h0, 32'h0, l);
        chk("mthi_lo", 64'(ifa.lo), 64'h5);
        issue(4'd4, 32'h3, 32'h4, l);
        chk("madd_lat", 64'(l), 64'd18);
`ifdef MULDIV_ACC_EN
        chk("madd_lo", 64'(ifa.lo), 64'h11);
`else
        chk("madd_lo", 64'(ifa.lo), 64'hC);
`endif
        chk("madd_hi", 64'(ifa.hi), 64'h0);
        issue(4'd8, 32'h0, 32'h0, l);
        issue(4'd9, 32'h5, 32'h0, l);
        issue(4'd6, 32'h3, 32'h4, l);
`ifdef MULDIV_ACC_EN
        chk("msub_hi", 64'(ifa.hi), 64'hFFFF_FFFF);
        chk("msub_lo", 64'(ifa.lo), 64'hFFFF_FFF9);
`else
        chk("msub_hi", 64'(ifa.hi), 64'h0);
        chk("msub_lo", 64'(ifa.lo), 64'hC);
`endif

        ph = ifa.hi;
        pl = ifa.lo;
        issue(4'd15, 32'h1234, 32'h1, l);
        chk("illegal_lat", 64'(l), 64'd1);
        chk("illegal_hi", 64'(ifa.hi), 64'(ph));
        chk("illegal_lo", 64'(ifa.lo), 64'(pl));

        // Flush a DIV ten edges after accept
        ifa.op_code = 4'd2; ifa.src1 = 32'd100; ifa.src2 = 32'd7; ifa.op_valid = 1'b1;
        @(negedge clk);
        ifa.op_valid = 1'b0;
        repeat (9) @(negedge clk);
        ifa.flush = 1'b1;
        @(negedge clk);
        ifa.flush = 1'b0;
        #1;
        chk("flush_busy", 64'(ifa.busy), 64'd0);
        chk("flush_ready", 64'(ifa.op_ready), 64'd1);
        chk("flush_hi", 64'(ifa.hi), 64'(ph));
        chk("flush_lo", 64'(ifa.lo), 64'(pl));
        issue(4'd0, 32'd6, 32'hFFFF_FFFD, l);
        chk("post_flush_lat", 64'(l), 64'd18);
        chk("post_flush_hi", 64'(ifa.hi), 64'hFFFF_FFFF);
        chk("post_flush_lo", 64'(ifa.lo), 64'hFFFF_FFEE);

        // op_valid held through a busy MULT
        ifa.op_code = 4'd0; ifa.src1 = 32'd3; ifa.src2 = 32'd5; ifa.op_valid = 1'b1;
        @(negedge clk);
        ifa.op_code = 4'd1; ifa.src1 = 32'd6; ifa.src2 = 32'd7;
        #1;
        k = 0;
        while (!ifa.op_ready && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("b2b_gap", 64'(k + 1), 64'd19);
        @(negedge clk);
        ifa.op_valid = 1'b0;
        #1;
        chk("b2b_first_hi", 64'(ifa.hi), 64'h0);
        chk("b2b_first_lo", 64'(ifa.lo), 64'd15);
        wait_done(l);
        chk("b2b_second_lat", 64'(l), 64'd18);
        chk("b2b_second_lo", 64'(ifa.lo), 64'd42);

        // flush together with op_valid in IDLE
        ph = ifa.hi;
        pl = ifa.lo;
        ifa.op_code = 4'd9; ifa.src1 = 32'h123; ifa.op_valid = 1'b1; ifa.flush = 1'b1;
        #1;
        chk("idle_flush_ready", 64'(ifa.op_ready), 64'd0);
        @(negedge clk);
        ifa.op_valid = 1'b0;
        ifa.flush    = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_flush_lo", 64'(ifa.lo), 64'(pl));
        chk("idle_flush_busy", 64'(ifa.busy), 64'd0);

        // Reset in the middle of a MULT
        ifa.op_code = 4'd0; ifa.src1 = 32'd7; ifa.src2 = 32'd9; ifa.op_valid = 1'b1;
        @(negedge clk);
        ifa.op_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_hi", 64'(ifa.hi), 64'd0);
        chk("rst_mid_lo", 64'(ifa.lo), 64'd0);
        chk("rst_mid_busy", 64'(ifa.busy), 64'd0);
        chk("rst_mid_done", 64'(ifa.done), 64'd0);
        chk("rst_mid_ready", 64'(ifa.op_ready), 64'd1);
        @(negedge clk);

        // 16-bit, 4 multiplier bits per cycle
        ifb.op_code = 4'd1; ifb.src1 = 16'hFFFF; ifb.src2 = 16'hFFFF; ifb.op_valid = 1'b1;
        #1;
        chk("w16_ready", 64'(ifb.op_ready), 64'd1);
        @(negedge clk);
        ifb.op_valid = 1'b0;
        #1;
        l = -1;
        for (int j = 0; j < 100; j++) begin
            if (ifb.done) begin
                l = j + 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        chk("w16_lat", 64'(l), 64'd6);
        chk("w16_hi", 64'(ifb.hi), 64'hFFFE);
        chk("w16_lo", 64'(ifb.lo), 64'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected $finish before time limit");
        $fatal(1, "time limit reached");
    end
endmodule
